// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-stream program loader: bus widths, RAM depth
// and the loader FSM state encoding.
package program_loader_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4096;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        RUN,
        ERR
    } state_e;

    // States in which the loader is still consuming the boot stream.
    function automatic logic accepts_bytes(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Boot-stream handshake plus CPU instruction-fetch bus seen by the loader.
interface program_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] D_BUS;

    modport master (
        output rx_data,
        output rx_valid,
        output address,
        input  rx_ready,
        input  D_BUS
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  address,
        output rx_ready,
        output D_BUS
    );
endinterface

// File: rtl/program_loader_ram.sv
// Program store: synchronous write from the loader, asynchronous read for the
// CPU fetch path. Contents are deliberately never reset.
module program_ram
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = program_loader_pkg::ADDR_W,
    parameter int DATA_W = program_loader_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, checksummed boot stream into program RAM and
// releases the CPU from reset once the image verifies.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = program_loader_pkg::ADDR_W,
    parameter int DATA_W = program_loader_pkg::DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             error
);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] length_q,    length_d;
    logic [7:0]        checksum_q,  checksum_d;
    logic              rx_ready_q,  rx_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              error_q,     error_d;

    logic              xfer;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rd_data;

    assign xfer = bus.rx_valid && rx_ready_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        length_d   = length_q;
        checksum_d = checksum_q;
        ram_we     = 1'b0;

        case (state_q)
            LEN_HI: begin
                if (xfer) begin
                    length_d = ADDR_W'({bus.rx_data[3:0], 8'h00});
                    state_d  = (bus.rx_data[7:4] != 4'h0) ? ERR : LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    length_d = length_q | ADDR_W'(bus.rx_data);
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    ram_we     = 1'b1;
                    checksum_d = checksum_q + bus.rx_data;
                    // A zero length field wraps to all-ones here, i.e. a full 4096-byte image.
                    if (wr_ptr_q == length_q - ADDR_W'(1)) begin
                        state_d = CHECK;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_d = (bus.rx_data == checksum_q) ? RUN : ERR;
                end
            end
            RUN:     state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase

        rx_ready_d  = accepts_bytes(state_d);
        cpu_reset_d = (state_d == RUN);
        load_done_d = (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= LEN_HI;
            wr_ptr_q    <= '0;
            length_q    <= '0;
            checksum_q  <= '0;
            rx_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b0;
            load_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            length_q    <= length_d;
            checksum_q  <= checksum_d;
            rx_ready_q  <= rx_ready_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            error_q     <= error_d;
        end
    end

    program_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_program_ram (
        .clock   (clock),
        .we      (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (DATA_W'(bus.rx_data)),
        .rd_addr (bus.address),
        .rd_data (ram_rd_data)
    );

    assign bus.rx_ready = rx_ready_q;
    assign bus.D_BUS    = (state_q == RUN) ? ram_rd_data : '0;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed boot streams checked every cycle against a
// byte-count based model of the loader protocol.
module tb_program_loader;

    localparam int AW = 12;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset, load_done, error;

    program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outcome follows purely from how many bytes have been accepted.
    logic       m_ready, m_run, m_err;
    int         m_cnt, m_len;
    logic [7:0] m_sum;
    logic [7:0] m_ram [4096];

    task automatic model_accept(input logic [7:0] b);
        if (m_cnt == 0) begin
            if (b[7:4] != 4'h0) m_err = 1'b1;
            else                m_len = int'(b[3:0]) * 256;
        end else if (m_cnt == 1) begin
            m_len = m_len + int'(b);
            if (m_len == 0) m_len = 4096;
        end else if (m_cnt < 2 + m_len) begin
            m_ram[m_cnt - 2] = b;
            m_sum = m_sum + b;
        end else begin
            if (b == m_sum) m_run = 1'b1;
            else            m_err = 1'b1;
        end
        m_cnt++;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ready = 1'b0; m_run = 1'b0; m_err = 1'b0;
            m_cnt = 0; m_len = 0; m_sum = 8'h00;
        end else begin
            if (bus.rx_valid && m_ready) model_accept(bus.rx_data);
            m_ready = !(m_run || m_err);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
            check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
            check("rst_load_done", 32'(load_done), 32'd0);
            check("rst_error", 32'(error), 32'd0);
            check("rst_dbus", 32'(bus.D_BUS), 32'd0);
        end else begin
            check("rx_ready", 32'(bus.rx_ready), 32'(m_ready));
            check("cpu_reset", 32'(cpu_reset), 32'(m_run));
            check("load_done", 32'(load_done), 32'(m_run));
            check("error", 32'(error), 32'(m_err));
            check("dbus", 32'(bus.D_BUS), m_run ? 32'(m_ram[bus.address]) : 32'd0);
        end
    end

    // Address driver: random fetches, restricted to the loaded range in RUN.
    logic          addr_manual = 1'b0;
    logic [AW-1:0] manual_addr = '0;
    initial begin
        bus.address = '0;
        forever begin
            @(posedge clock);
            #2;
            if (addr_manual)  bus.address = manual_addr;
            else if (m_run)   bus.address = AW'($urandom_range(0, m_len - 1));
            else              bus.address = AW'($urandom);
        end
    end

    task automatic peek(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
        addr_manual = 1'b1;
        manual_addr = a;
        @(posedge clock);
        #3;
        check(name, 32'(bus.D_BUS), 32'(exp));
        addr_manual = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold_rx_ready", 32'(bus.rx_ready), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_reset", 32'(bus.rx_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] q[$], input int gap_min, input int gap_max);
        foreach (q[i]) send_byte(q[i], $urandom_range(gap_min, gap_max));
    endtask

    task automatic build(input int len, input bit good_sum, output logic [7:0] q[$]);
        logic [7:0] sum;
        logic [7:0] b;
        logic [11:0] l12;
        q = {};
        sum = 8'h00;
        l12 = 12'(len);
        q.push_back({4'h0, l12[11:8]});
        q.push_back(l12[7:0]);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            sum = sum + b;
        end
        q.push_back(good_sum ? sum : sum ^ 8'(1 + $urandom_range(0, 254)));
    endtask

    task automatic sweep(input logic [7:0] q[$], input int len, input string name);
        for (int a = 0; a < len; a++) peek(AW'(a), q[a + 2], name);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] s[$];
        int len;
        bit good;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Three-byte image, checksum 16.
        do_reset();
        q = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
        send_stream(q, 0, 0);
        check("short_done_early", 32'(load_done), 32'd0);
        send_byte(8'h16, 0);
        check("short_load_done", 32'(load_done), 32'd1);
        check("short_cpu_reset", 32'(cpu_reset), 32'd1);
        peek(12'h000, 8'hA1, "short_addr0");
        peek(12'h001, 8'hB2, "short_addr1");
        peek(12'h002, 8'hC3, "short_addr2");
        $display("stream short_ok len=3 load_done=%0b", load_done);

        // Bad checksum.
        do_reset();
        q = '{8'h00, 8'h02, 8'h10, 8'h20, 8'h31};
        send_stream(q, 0, 0);
        check("badsum_error", 32'(error), 32'd1);
        check("badsum_cpu_reset", 32'(cpu_reset), 32'd0);
        check("badsum_rx_ready", 32'(bus.rx_ready), 32'd0);
        peek(12'h000, 8'h00, "badsum_dbus0");
        peek(12'hABC, 8'h00, "badsum_dbusABC");
        $display("stream bad_checksum error=%0b", error);

        // Bad header, trailing bytes must be ignored.
        do_reset();
        send_byte(8'h10, 0);
        check("badhdr_error", 32'(error), 32'd1);
        q = '{8'h00, 8'h01, 8'h55, 8'h55};
        send_stream(q, 0, 0);
        check("badhdr_still_error", 32'(error), 32'd1);
        check("badhdr_no_done", 32'(load_done), 32'd0);
        $display("stream bad_header error=%0b", error);

        // Full 4096-byte image via a zero length field.
        do_reset();
        q = '{8'h00, 8'h00};
        for (int i = 0; i < 4096; i++) q.push_back(8'h01);
        q.push_back(8'h00);
        send_stream(q, 0, 0);
        check("full_load_done", 32'(load_done), 32'd1);
        peek(12'hFFF, 8'h01, "full_addrFFF");
        peek(12'h000, 8'h01, "full_addr000");
        $display("stream full len=4096 load_done=%0b", load_done);

        // Same image delivered with idle gaps and back-to-back.
        build(16, 1'b1, s);
        do_reset();
        send_stream(s, 2, 2);
        check("gap_load_done", 32'(load_done), 32'd1);
        sweep(s, 16, "gap_sweep");
        do_reset();
        send_stream(s, 0, 0);
        check("b2b_load_done", 32'(load_done), 32'd1);
        sweep(s, 16, "b2b_sweep");
        $display("stream gap_vs_b2b len=16 load_done=%0b", load_done);

        // Reset pulsed mid-load, then a fresh one-byte image.
        do_reset();
        q = '{8'h00, 8'h05, 8'h11, 8'h22};
        send_stream(q, 0, 0);
        reset = 1'b0;
        #2;
        check("abort_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        q = '{8'h00, 8'h01, 8'h5A, 8'h5A};
        send_stream(q, 0, 0);
        check("abort_reload_done", 32'(load_done), 32'd1);
        check("abort_reload_error", 32'(error), 32'd0);
        peek(12'h000, 8'h5A, "abort_addr0");
        $display("stream abort_reload load_done=%0b", load_done);

        // Random streams.
        for (int t = 0; t < 12; t++) begin
            len  = $urandom_range(1, 40);
            good = ($urandom_range(0, 3) != 0);
            build(len, good, s);
            if ($urandom_range(0, 5) == 0) begin
                s[0] = s[0] | 8'h40;
                good = 1'b0;
            end
            do_reset();
            send_stream(s, 0, 2);
            check("rand_load_done", 32'(load_done), 32'(good));
            check("rand_error", 32'(error), 32'(!good));
            if (good) sweep(s, len, "rand_sweep");
            $display("stream random %0d len=%0d load_done=%0b error=%0b", t, len, load_done, error);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
